// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder counter: resolution codes and
// the single-step direction lookup on the AB Gray cycle.
package quad_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // {valid, up}: forward cycle on {A,B} is 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] fwd(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] nxt;
    logic [1:0] prv;
    nxt = {~prev[0], prev[1]};
    prv = {prev[0], ~prev[1]};
    return {(curr == nxt) || (curr == prv), curr == nxt};
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: synchroniser chain followed by a persistence filter that
// only accepts a new level after it has held for FILT_LEN cycles.
module quad_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_init,
  input  logic i_d,
  output logic o_sync,
  output logic o_filt
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_sync = w_sync;
  assign o_filt = r_filt;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  // During init the filter tracks the synchroniser directly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (i_init || (r_cnt == CW'(FILT_LEN))) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else if (w_sync != r_filt) begin
      r_cnt  <= r_cnt + CW'(1);
    end else begin
      r_cnt  <= '0;
    end
  end

endmodule

// File: rtl/quad_enc_counter.sv
// Quadrature encoder position counter with filtered inputs, x1/x2/x4 decode,
// wrap or saturate counting, clear/preload, step strobe and sticky error.
module quad_enc_counter #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 quadA,
  input  logic                 quadB,
  input  logic [1:0]           mode,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 step,
  output logic                 err
);

  import quad_pkg::*;

  localparam int unsigned          IW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam bit                   SAT     = (SATURATE != 0);

  logic [IW-1:0]        r_init;
  logic                 r_ap, r_bp;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_dir, r_step, r_err;
  logic                 w_init, w_sa, w_sb, w_af, w_bf;
  logic [1:0]           w_fwd;
  logic                 w_illegal, w_a_chg, w_ev, w_up;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .i_init(w_init), .i_d(quadA), .o_sync(w_sa), .o_filt(w_af)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .i_init(w_init), .i_d(quadB), .o_sync(w_sb), .o_filt(w_bf)
  );

  assign w_init = (r_init != '0);
  assign count  = r_count;
  assign dir    = r_dir;
  assign step   = r_step;
  assign err    = r_err;

  // Init window lets whatever position the encoder rests at become the history
  always_ff @(posedge clk) begin
    if (rst)         r_init <= IW'(SYNC_STAGES + 1);
    else if (w_init) r_init <= r_init - IW'(1);
  end

  always_comb begin
    w_fwd     = fwd({r_ap, r_bp}, {w_af, w_bf});
    w_illegal = (w_af != r_ap) && (w_bf != r_bp);
    w_a_chg   = (w_af != r_ap) && (w_bf == r_bp);
    w_ev      = 1'b0;
    w_up      = 1'b0;
    if (!w_init) begin
      if ((mode & MODE_X4) != 2'd0) begin
        w_ev = w_fwd[1];
        w_up = w_fwd[0];
      end else if (mode == MODE_X2) begin
        w_ev = w_a_chg;
        w_up = (w_af != w_bf);
      end else if (mode == MODE_X1) begin
        w_ev = w_a_chg && w_af;
        w_up = !w_bf;
      end
    end
  end

  // clr/load override the count but leave decode history running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ap    <= 1'b0;
      r_bp    <= 1'b0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_init) begin
        r_ap <= w_sa;
        r_bp <= w_sb;
      end else begin
        r_ap <= w_af;
        r_bp <= w_bf;
      end
      if (w_illegal && !w_init) r_err <= 1'b1;
      else if (err_clr)         r_err <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (load) begin
        r_count <= load_val;
      end else if (w_ev) begin
        r_step <= 1'b1;
        r_dir  <= w_up;
        if (w_up) begin
          if (!SAT || (r_count != CNT_MAX)) r_count <= r_count + CNT_WIDTH'(1);
        end else if (!SAT || (r_count != '0)) begin
          r_count <= r_count - CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_counter.sv
// Bench for quad_enc_counter: a wrapping 16-bit instance and a saturating 4-bit
// instance share stimulus and are checked every cycle against a pin-level model.
module tb_quad_enc_counter;

  localparam int unsigned S    = 2;
  localparam int unsigned F    = 4;
  localparam int unsigned NMAX = 20000;

  logic        clk = 1'b0;
  logic        rst, quadA, quadB, clr, load, err_clr;
  logic [1:0]  mode;
  logic [15:0] load_val, count;
  logic [3:0]  count_s;
  logic        dir, step, err, dir_s, step_s, err_s;

  always #5 clk = ~clk;

  quad_enc_counter dut (
    .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err)
  );

  quad_enc_counter #(.CNT_WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val[3:0]), .err_clr(err_clr),
    .count(count_s), .dir(dir_s), .step(step_s), .err(err_s)
  );

  typedef struct {
    logic [15:0] c16;
    logic [3:0]  c4;
    logic        dir, step, err, fa, fb, pa, pb;
    int          init;
  } mdl_t;

  mdl_t m;
  bit   raw_a [NMAX];
  bit   raw_b [NMAX];
  int   n = 0;

  function automatic bit rd(input bit ch, input int i);
    if (i < 0 || i >= int'(NMAX)) return 1'b0;
    return ch ? raw_b[i] : raw_a[i];
  endfunction

  // New level is adopted once the F synchronised samples before it all disagreed
  function automatic logic filt_next(input bit ch, input logic f, input int k);
    bit held = 1'b1;
    for (int j = 1; j <= int'(F); j++)
      if (rd(ch, k - int'(S) - j) == f) held = 1'b0;
    return held ? logic'(rd(ch, k - int'(S))) : f;
  endfunction

  function automatic int gidx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic mdl_t mstep(input mdl_t m0, input int k);
    mdl_t r = m0;
    int   d;
    bit   ev, up, single;
    r.step = 1'b0;
    if (rst) begin
      r.c16 = '0; r.c4 = '0; r.dir = 1'b0; r.err = 1'b0;
      r.fa = 1'b0; r.fb = 1'b0; r.pa = 1'b0; r.pb = 1'b0;
      r.init = int'(S) + 1;
      return r;
    end
    d      = (gidx(m0.fa, m0.fb) - gidx(m0.pa, m0.pb) + 4) % 4;
    single = (d == 1) || (d == 3);
    up     = (d == 1);
    ev     = 1'b0;
    if (m0.init > 0) begin
      r.fa = rd(1'b0, k - int'(S));
      r.fb = rd(1'b1, k - int'(S));
      r.pa = r.fa;
      r.pb = r.fb;
      r.init = m0.init - 1;
    end else begin
      if (mode >= 2'd2)      ev = single;
      else if (mode == 2'd1) ev = single && (m0.fa != m0.pa);
      else                   ev = single && m0.fa && !m0.pa;
      r.pa = m0.fa;
      r.pb = m0.fb;
      r.fa = filt_next(1'b0, m0.fa, k);
      r.fb = filt_next(1'b1, m0.fb, k);
    end
    if (m0.init == 0 && d == 2) r.err = 1'b1;
    else if (err_clr)           r.err = 1'b0;
    if (clr) begin
      r.c16 = '0; r.c4 = '0;
    end else if (load) begin
      r.c16 = load_val; r.c4 = load_val[3:0];
    end else if (ev) begin
      r.step = 1'b1;
      r.dir  = up;
      r.c16  = up ? m0.c16 + 16'd1 : m0.c16 - 16'd1;
      if (up && m0.c4 != 4'd15)      r.c4 = m0.c4 + 4'd1;
      else if (!up && m0.c4 != 4'd0) r.c4 = m0.c4 - 4'd1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    raw_a[n] <= rst ? 1'b0 : quadA;
    raw_b[n] <= rst ? 1'b0 : quadB;
    m        <= mstep(m, n);
    n        <= n + 1;
  end

  int         tests = 0;
  int         fails = 0;
  int         nsteps;
  bit         chk_en = 1'b0;
  int         pos;
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (step === 1'b1) nsteps++;
    if (chk_en) begin
      chk("m_count",  32'(count),   32'(m.c16));
      chk("m_dir",    32'(dir),     32'(m.dir));
      chk("m_step",   32'(step),    32'(m.step));
      chk("m_err",    32'(err),     32'(m.err));
      chk("m_count4", 32'(count_s), 32'(m.c4));
      chk("m_dir4",   32'(dir_s),   32'(m.dir));
      chk("m_step4",  32'(step_s),  32'(m.step));
      chk("m_err4",   32'(err_s),   32'(m.err));
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic move(input bit fw, input int hold);
    pos = (pos + (fw ? 1 : 3)) % 4;
    {quadA, quadB} = gray[pos];
    ticks(hold);
  endtask

  initial begin
    int unsigned r;
    rst = 1'b1; quadA = 1'b1; quadB = 1'b1; mode = 2'd2;
    clr = 1'b0; load = 1'b0; load_val = '0; err_clr = 1'b0; pos = 2; nsteps = 0;
    ticks(5);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dir",   32'(dir),   32'd0);
    chk("rst_step",  32'(step),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    ticks(10);

    // x4 forward from 11, first step exactly 7 edges after sampling
    nsteps = 0;
    move(1'b1, 7);
    chk("lat_before", 32'(step), 32'd0);
    tick();
    chk("lat_hit",    32'(step), 32'd1);
    chk("lat_count",  32'(count), 32'd1);
    ticks(2);
    repeat (7) move(1'b1, 10);
    chk("fwd_count", 32'(count), 32'd8);
    chk("fwd_dir",   32'(dir),   32'd1);
    chk("fwd_steps", 32'(nsteps), 32'd8);
    chk("fwd_err",   32'(err),   32'd0);

    // reverse in x1 then x2
    mode = 2'd0; clr = 1'b1; tick(); clr = 1'b0; tick();
    nsteps = 0;
    repeat (12) move(1'b0, 10);
    chk("x1_count", 32'(count), 32'd65533);
    chk("x1_steps", 32'(nsteps), 32'd3);
    chk("x1_dir",   32'(dir),   32'd0);
    mode = 2'd1;
    repeat (12) move(1'b0, 10);
    chk("x2_count", 32'(count), 32'd65527);
    chk("x2_dir",   32'(dir),   32'd0);

    // glitch rejection, then a held change
    mode = 2'd2; nsteps = 0;
    quadA = ~quadA; ticks(3); quadA = ~quadA; ticks(12);
    chk("glitch_steps", 32'(nsteps), 32'd0);
    chk("glitch_count", 32'(count), 32'd65527);
    move(1'b1, 10);
    chk("held_steps", 32'(nsteps), 32'd1);
    chk("held_count", 32'(count), 32'd65528);

    // illegal double-edge, err_clr, and set-wins-over-clear
    nsteps = 0; pos = 1; {quadA, quadB} = gray[pos]; ticks(12);
    chk("ill_err",   32'(err),   32'd1);
    chk("ill_count", 32'(count), 32'd65528);
    chk("ill_steps", 32'(nsteps), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("errclr", 32'(err), 32'd0);
    pos = 3; {quadA, quadB} = gray[pos]; ticks(7);
    err_clr = 1'b1; tick(); err_clr = 1'b0; ticks(3);
    chk("ill_setwins", 32'(err), 32'd1);

    // wrap (16-bit) and saturate (4-bit) at both ends
    load_val = 16'hFFFF; load = 1'b1; tick(); load = 1'b0; tick();
    chk("load_count",  32'(count),   32'd65535);
    chk("load_count4", 32'(count_s), 32'd15);
    move(1'b1, 10);
    chk("wrap_up",  32'(count),   32'd0);
    chk("sat_up",   32'(count_s), 32'd15);
    chk("sat_step", 32'(step_s) | 32'(nsteps > 0), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    move(1'b0, 10);
    chk("wrap_dn",  32'(count),   32'd65535);
    chk("sat_dn",   32'(count_s), 32'd0);
    chk("sat_dir",  32'(dir_s),   32'd0);

    // clr+load coincident with a counted event
    load_val = 16'd1234; nsteps = 0;
    move(1'b1, 7);
    clr = 1'b1; load = 1'b1; tick(); clr = 1'b0; load = 1'b0; ticks(5);
    chk("clrld_count", 32'(count), 32'd0);
    chk("clrld_steps", 32'(nsteps), 32'd0);

    // reset in the middle of a transition, then resume
    move(1'b1, 4);
    rst = 1'b1; tick();
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_dir",   32'(dir),   32'd0);
    chk("mrst_step",  32'(step),  32'd0);
    chk("mrst_err",   32'(err),   32'd0);
    rst = 1'b0; ticks(12);
    repeat (3) move(1'b1, 10);
    chk("resume_count", 32'(count), 32'd3);
    chk("resume_dir",   32'(dir),   32'd1);

    // randomized pins, mode changes and control pulses
    for (int i = 0; i < 4000; i++) begin
      r       = $urandom_range(0, 999);
      clr     = (r < 10);
      load    = (r >= 10 && r < 20);
      err_clr = (r >= 20 && r < 40);
      rst     = (r >= 40 && r < 43);
      if (load) load_val = 16'($urandom);
      if (r >= 100 && r < 150)      quadA = ~quadA;
      else if (r >= 150 && r < 200) quadB = ~quadB;
      else if (r >= 200 && r < 205) begin quadA = ~quadA; quadB = ~quadB; end
      else if (r >= 205 && r < 225) mode = 2'($urandom_range(0, 3));
      tick();
    end
    clr = 1'b0; load = 1'b0; err_clr = 1'b0; rst = 1'b0;
    ticks(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
